timer_irq_ctrl: RTL
===================

// Module: timer_irq_ctrl
// PURPOSE
//  Downstream consumer of the periodic timer pulses. Latches one-cycle pulses
//  from NSRC timer instances into pending bits and applies a per-source enable
//  mask. Presents one prioritised interrupt request to the CPU and runs an
//  irq/ack/eoi handshake with it. Records overrun when a pulse arrives for a
//  source that is still pending.
// PARAMETERS
//  NSRC      4              number of timer pulse sources (>=2)
//  IDW       $clog2(NSRC)   width of irq_id
//  MASK_RST  {NSRC{1'b1}}   mask register value after reset (1 = enabled)
// PORTS
//  clk      in   1     system clock, all logic on rising edge
//  reset    in   1     asynchronous, active-low reset (0 = reset)
//  pulse    in   NSRC  one-cycle pulses from timer instances, bit i = source i
//  mask_we  in   1     write strobe for the mask register
//  mask_in  in   NSRC  new mask value, loaded when mask_we=1
//  ack      in   1     CPU accepts the presented interrupt (1-cycle strobe)
//  eoi      in   1     CPU finished the service routine (1-cycle strobe)
//  irq      out  1     interrupt request to CPU
//  irq_id   out  IDW   index of the requesting source, valid while irq=1
//  mask     out  NSRC  current mask register
//  pending  out  NSRC  latched, not yet acknowledged pulses
//  overrun  out  NSRC  sticky: pulse lost because pending[i] was already 1
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, irq=0, irq_id=0, pending=0, overrun=0,
//   mask=MASK_RST. Release is synchronous to the next clk edge.
//  Pending: pulse[i]=1 at edge -> pending[i]=1. Set is independent of mask;
//   masked sources stay pending and are not requested.
//  Overrun: pulse[i]=1 while pending[i]=1 and no clear this edge -> overrun[i]=1.
//   overrun[i] clears on the ack that clears pending[i], unless set again at the
//   same edge.
//  FSM, registered state:
//   IDLE: any (pending & mask) -> REQ. irq_id = lowest set index of
//    (pending & mask), latched at entry. irq=1 from that edge on.
//   REQ: irq=1, irq_id held stable.
//    ack=1 -> SERVICE. pending[irq_id] cleared. irq=0 next edge.
//    mask write clears mask[irq_id] without ack -> IDLE. irq=0 next edge.
//     pending stays set.
//    ack and such a mask write at the same edge -> ack wins.
//   SERVICE: irq=0. eoi=1 -> IDLE. Re-arbitration starts in IDLE next cycle.
//  ack outside REQ is ignored. eoi outside SERVICE is ignored.
//  Latency: pulse in cycle 0, source enabled, FSM idle -> pending=1 after
//   edge 1, irq=1 after edge 2. Back-to-back: eoi at edge k with another
//   enabled pending source -> IDLE at k, irq=1 at k+1.
//  Simultaneous pulse[i] and ack clearing pending[i]: set wins, pending[i]
//   stays 1, overrun[i] is not set.
//  Mask write takes effect at the edge it is sampled. Writes are accepted in
//   any state.
//  Priority is fixed: index 0 highest. No preemption: a higher-priority
//   pending source waits for eoi.
//  All outputs are registered. No combinational path from inputs to outputs.
// TESTING
//  1. Reset: reset=0 mid-REQ with irq=1 -> irq, pending, overrun = 0
//     immediately; mask=MASK_RST.
//  2. Single source: pulse[2] in cycle 0 -> pending=4'b0100 @1, irq=1 and
//     irq_id=2 @2. ack -> irq=0, pending=0. eoi -> IDLE.
//  3. Priority: pulse=4'b1010 together -> irq_id=1 first. ack+eoi -> irq_id=3
//     presented one cycle after eoi.
//  4. Mask: mask_in=4'b1110 with pulse[0] -> pending[0]=1, irq stays 0.
//     Unmask -> irq=1, irq_id=0 next edge. Masking in REQ -> irq drops,
//     pending[0] kept.
//  5. Overrun: pulse[1] twice with no ack -> overrun=4'b0010. Pulse in same
//     cycle as ack of source 1 -> pending[1]=1, overrun cleared.
//  6. Handshake noise: ack in IDLE/SERVICE and eoi in IDLE/REQ -> no state
//     change. Verify with 25 random pulse/ack/eoi streams against a model.

Source files
------------

// File: rtl/timer_irq_ctrl.sv
// Latches timer pulses into pending bits, masks them and presents one
// fixed-priority interrupt to the CPU through an irq/ack/eoi handshake.
module timer_irq_ctrl #(
    parameter int unsigned     NSRC     = 4,
    parameter int unsigned     IDW      = $clog2(NSRC),
    parameter logic [NSRC-1:0] MASK_RST = {NSRC{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] pulse,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_in,
    input  logic            ack,
    input  logic            eoi,
    output logic            irq,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic            w_req_ack;
    logic            w_drop;
    logic            w_any;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_mask_eff;
    logic [NSRC-1:0] w_cand;
    logic [IDW-1:0]  w_win;

    // A mask write is already in force at the edge that samples it.
    assign w_req_ack  = (r_state == ST_REQ) && ack;
    assign w_clr      = w_req_ack ? (NSRC'(1) << irq_id) : '0;
    assign w_mask_eff = mask_we ? mask_in : mask;
    assign w_cand     = pending & w_mask_eff;
    assign w_any      = |w_cand;
    assign w_drop     = mask_we && !mask_in[irq_id];

    // Lowest index wins.
    always_comb begin
        w_win = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
            mask    <= MASK_RST;
            pending <= '0;
            overrun <= '0;
        end else begin
            // A new pulse beats the ack clear of the same source.
            pending <= (pending & ~w_clr) | pulse;
            overrun <= (overrun & ~w_clr) | (pulse & pending & ~w_clr);
            if (mask_we) begin
                mask <= mask_in;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_REQ;
                        irq     <= 1'b1;
                        irq_id  <= w_win;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        r_state <= ST_SERVICE;
                        irq     <= 1'b0;
                    end else if (w_drop) begin
                        r_state <= ST_IDLE;
                        irq     <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    irq     <= 1'b0;
                end
            endcase
        end
    end

endmodule
